swan256_word_shim: RTL and testbench

Word-serial front end for the SWAN-256 block cores. Collects a 256-bit key via a word-addressed write port and a 256-bit data block via a 32-bit valid/ready stream. Launches one SWAN256_ENC or SWAN256_DEC operation, which is port-identical, so the same shim serves both. Returns the 256-bit result as a 32-bit valid/ready stream. Sits directly upstream and downstream of the core, between the bus-side datapath and the core's wide start/ready interface.

---
 rtl/swan256_word_shim.sv | 192 +++++++++++++++++++
 tb/tb_swan256_word_shim.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/swan256_word_shim.sv
// ---------------------------------------------------------------------------
// swan256_word_shim
//
// Word-serial front end for the SWAN-256 block cores (encrypt or decrypt;
// both cores share one port list). A 256-bit key is written one word at a
// time through a word-addressed port. A 256-bit block arrives as eight
// 32-bit words on a valid/ready stream. The shim launches one core
// operation and returns the 256-bit result as eight words on a second
// valid/ready stream.
//
// Word w of the key, block or result occupies bits [32*w +: 32] of the
// wide vector. Word 0 is the first word streamed.
//
// Ports
//   clk, rst               clock (rising edge), async active-high reset
//   key_we/key_addr/key_data  key word write port (honoured in LOAD only)
//   in_valid/in_ready/in_data    input word stream
//   out_valid/out_ready/out_data result word stream
//   busy                   high while the core owns the block (START, WAIT)
//   timeout_err            sticky abort flag; cleared by next accepted word
//   blk_count              completed-block counter, wraps at 16 bits
//   core_start/core_inp/core_key  launch interface to the core
//   core_ready/core_out    completion interface from the core
//
// All outputs come from registers or from a decode of the state register,
// so neither in_valid nor out_ready reaches an output combinationally.
// ---------------------------------------------------------------------------
module swan256_word_shim #(
  parameter int BLOCK_SIZE = 256,
  parameter int KEY_SIZE   = 256,
  parameter int WORD_W     = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_we,
  input  logic [2:0]            key_addr,
  input  logic [WORD_W-1:0]     key_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_W-1:0]     out_data,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [15:0]           blk_count,
  output logic                  core_start,
  output logic [BLOCK_SIZE-1:0] core_inp,
  output logic [KEY_SIZE-1:0]   core_key,
  input  logic                  core_ready,
  input  logic [BLOCK_SIZE-1:0] core_out
);

  localparam int NW = BLOCK_SIZE / WORD_W;
  localparam int NK = KEY_SIZE / WORD_W;
  localparam int CW = $clog2(NW);
  // Timeout counter only has to reach TIMEOUT-1; abort fires on that cycle.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CW-1:0] LAST_WORD = CW'(NW - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    UNLOAD = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [NK-1:0][WORD_W-1:0] key_q;
  logic [NW-1:0][WORD_W-1:0] blk_q;
  logic [NW-1:0][WORD_W-1:0] res_q;
  logic [CW-1:0]             wcnt;
  logic [CW-1:0]             rcnt;
  logic [TW-1:0]             tcnt;

  logic in_fire;
  logic out_fire;
  logic capture;
  logic abort;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and state-decoded strobes. Handshake qualifiers
  // (in_fire, out_fire) are internal only; the ready/valid outputs depend
  // on the state alone.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    core_start = 1'b0;
    in_fire    = 1'b0;
    out_fire   = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        in_fire  = in_valid;
        if (in_valid && (wcnt == LAST_WORD)) begin
          state_next = START;
        end
      end
      START: begin
        busy       = 1'b1;
        core_start = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (core_ready) begin
          capture    = 1'b1;
          state_next = UNLOAD;
        end else if ((TIMEOUT != 0) && (tcnt == TMO_LAST)) begin
          abort      = 1'b1;
          state_next = LOAD;
        end
      end
      UNLOAD: begin
        out_valid = 1'b1;
        out_fire  = out_ready;
        if (out_ready && (rcnt == LAST_WORD)) begin
          state_next = LOAD;
        end
      end
      default: begin
        state_next = LOAD;
      end
    endcase
  end

  // Datapath registers. The block and key registers are only written in
  // LOAD, which keeps core_inp/core_key frozen from START through UNLOAD.
  // A key write that coincides with an input handshake lands in the same
  // block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q       <= '0;
      blk_q       <= '0;
      res_q       <= '0;
      wcnt        <= '0;
      rcnt        <= '0;
      tcnt        <= '0;
      timeout_err <= 1'b0;
      blk_count   <= '0;
    end else begin
      if ((state == LOAD) && key_we) begin
        key_q[key_addr] <= key_data;
      end
      if (in_fire) begin
        blk_q[wcnt] <= in_data;
        wcnt        <= wcnt + 1'b1;
        timeout_err <= 1'b0;
      end
      if (state == START) begin
        tcnt <= '0;
      end
      if ((state == WAIT) && !core_ready && !abort) begin
        tcnt <= tcnt + 1'b1;
      end
      if (abort) begin
        timeout_err <= 1'b1;
      end
      if (capture) begin
        res_q     <= core_out;
        blk_count <= blk_count + 16'd1;
      end
      if (out_fire) begin
        rcnt <= rcnt + 1'b1;
      end
    end
  end

  assign core_inp = blk_q;
  assign core_key = key_q;
  // rcnt and res_q only change on a handshake or capture, so the word holds
  // steady while the downstream stalls.
  assign out_data = res_q[rcnt];

endmodule

// File: tb/tb_swan256_word_shim.sv
module tb_swan256_word_shim;

  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_we;
  logic [2:0]   key_addr;
  logic [31:0]  key_data;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         busy;
  logic         timeout_err;
  logic [15:0]  blk_count;
  logic         core_start;
  logic [255:0] core_inp;
  logic [255:0] core_key;
  logic         core_ready = 1'b0;
  logic [255:0] core_out = '0;

  int total = 0;
  int bad = 0;

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  swan256_word_shim #(
    .BLOCK_SIZE(256),
    .KEY_SIZE(256),
    .WORD_W(32),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_we(key_we),
    .key_addr(key_addr),
    .key_data(key_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .busy(busy),
    .timeout_err(timeout_err),
    .blk_count(blk_count),
    .core_start(core_start),
    .core_inp(core_inp),
    .core_key(core_key),
    .core_ready(core_ready),
    .core_out(core_out)
  );

  // Stand-in block core: a keyed word-reversing mix with a programmable
  // latency. It is never reset, so a result still in flight when the shim
  // is reset arrives later and must be ignored.
  logic         core_hold = 1'b0;
  int           core_lat = 2;
  logic         pend = 1'b0;
  int           lat_cnt = 0;
  logic [255:0] cap_inp = '0;
  logic [255:0] cap_key = '0;

  function automatic logic [255:0] stubMix(input logic [255:0] i, input logic [255:0] k);
    logic [255:0] r;
    for (int w = 0; w < 8; w++) begin
      r[w*32 +: 32] = (i[(7-w)*32 +: 32] ^ k[w*32 +: 32]) + 32'(w);
    end
    return r;
  endfunction

  always @(posedge clk) begin
    core_ready <= 1'b0;
    if (pend) begin
      if (lat_cnt == 0) begin
        core_ready <= 1'b1;
        core_out   <= stubMix(cap_inp, cap_key);
        pend       <= 1'b0;
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end else if (core_start && !core_hold) begin
      pend    <= 1'b1;
      lat_cnt <= core_lat;
      cap_inp <= core_inp;
      cap_key <= core_key;
    end
  end

  // Reference model state: key words, block words, expected result words
  // and the number of completed blocks.
  logic [31:0] key_m [8];
  logic [31:0] blk_in [8];
  logic [31:0] exp_out [8];
  int          blk_m = 0;

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Each result word is the key-mixed input word taken from the opposite
  // end of the block, plus its own index.
  task automatic computeExpected();
    for (int w = 0; w < 8; w++) begin
      exp_out[w] = (blk_in[7-w] ^ key_m[w]) + 32'(w);
    end
  endtask

  // Monitors: core_start pulse count, the one-cycle core_ready -> out_valid
  // latency, and whether out_valid ever rose while being watched.
  int   start_cnt = 0;
  logic prev_rdy_wait = 1'b0;
  logic ovalid_seen = 1'b0;

  always @(negedge clk) begin
    if (core_start) start_cnt++;
    if (out_valid) ovalid_seen = 1'b1;
    if (prev_rdy_wait && !rst) checkOutput("ovalid_latency", out_valid, 1);
    prev_rdy_wait = core_ready && busy && !core_start && !rst;
  end

  task automatic checkResetValues(input string pfx);
    checkOutput({pfx, "_in_ready"}, in_ready, 1);
    checkOutput({pfx, "_out_valid"}, out_valid, 0);
    checkOutput({pfx, "_out_data"}, out_data, 0);
    checkOutput({pfx, "_busy"}, busy, 0);
    checkOutput({pfx, "_timeout_err"}, timeout_err, 0);
    checkOutput({pfx, "_blk_count"}, blk_count, 0);
    checkOutput({pfx, "_core_start"}, core_start, 0);
    checkOutput({pfx, "_core_inp"}, core_inp, 0);
    checkOutput({pfx, "_core_key"}, core_key, 0);
  endtask

  task automatic writeKeyAll(input logic [31:0] val);
    for (int a = 0; a < 8; a++) begin
      @(negedge clk);
      key_we   = 1'b1;
      key_addr = 3'(a);
      key_data = val;
      key_m[a] = val;
    end
    @(negedge clk);
    key_we = 1'b0;
  endtask

  // Streams the first nwords of blk_in, optionally with idle bubbles and
  // key writes issued alongside (which the model applies, as the shim is in
  // LOAD). Returns at the negedge after the last handshake.
  task automatic applyStimulus(input int nwords, input bit bubbles, input bit rand_key, input bit chk_terr);
    for (int w = 0; w < nwords; w++) begin
      int  guard = 0;
      bit  done = 0;
      while (!done) begin
        bit accepted;
        @(negedge clk);
        key_we = 1'b0;
        if (rand_key && in_ready && ($urandom_range(0, 7) == 0)) begin
          key_we   = 1'b1;
          key_addr = 3'($urandom_range(0, 7));
          key_data = $urandom;
          key_m[key_addr] = key_data;
        end
        if (bubbles && ($urandom_range(0, 2) == 0)) begin
          in_valid = 1'b0;
        end else begin
          in_valid = 1'b1;
          in_data  = blk_in[w];
        end
        accepted = in_valid && in_ready;
        @(posedge clk);
        if (accepted) done = 1;
        guard++;
        if (!done && guard > 200) begin
          checkOutput("in_accept_timeout", 0, 1);
          in_valid = 1'b0;
          key_we   = 1'b0;
          return;
        end
      end
      if (w == 0 && chk_terr) begin
        #1;
        checkOutput("terr_clear", timeout_err, 0);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    key_we   = 1'b0;
    if (nwords == 8) checkOutput("start_latency", core_start, 1);
  endtask

  // Collects the eight result words, comparing out_data against the model
  // on every cycle out_valid is high (so a stalled word must hold).
  task automatic collectOutput(input bit stall);
    int got = 0;
    int guard = 0;
    int c0 = 0;
    int clast = 0;
    while (got < 8 && guard < 400) begin
      @(negedge clk);
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid) begin
        checkOutput($sformatf("word%0d", got), out_data, exp_out[got]);
        if (out_ready) begin
          if (got == 0) c0 = guard;
          clast = guard;
          got++;
        end
      end
      @(posedge clk);
      guard++;
    end
    @(negedge clk);
    out_ready = 1'b0;
    if (got < 8) checkOutput("out_timeout", got, 8);
    else if (!stall) checkOutput("out_consecutive", clast - c0, 7);
  endtask

  task automatic runBlock(input bit stall, input bit bubbles, input bit rand_key);
    start_cnt = 0;
    applyStimulus(8, bubbles, rand_key, 0);
    computeExpected();
    collectOutput(stall);
    blk_m++;
    checkOutput("blk_count", blk_count, 16'(blk_m));
    checkOutput("start_pulses", start_cnt, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no_finish want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    rst = 1'b1;
    key_we = 1'b0; key_addr = '0; key_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    for (int a = 0; a < 8; a++) key_m[a] = '0;
    #12;
    checkResetValues("reset");
    @(negedge clk);
    rst = 1'b0;

    // Known block with an all-ones key, clean streams.
    writeKeyAll(32'hffffffff);
    for (int w = 0; w < 8; w++) blk_in[w] = (w % 2 == 0) ? 32'hf0debc9a : 32'h78563412;
    core_lat = 3;
    runBlock(0, 0, 0);

    // Random blocks with bubbles, backpressure, key writes, varied latency.
    for (int b = 0; b < 12; b++) begin
      for (int w = 0; w < 8; w++) blk_in[w] = $urandom;
      core_lat = $urandom_range(0, 6);
      runBlock(1, 1, 1);
    end

    // Key lockout: a write during WAIT must not reach the key register.
    writeKeyAll(32'hffffffff);
    for (int w = 0; w < 8; w++) blk_in[w] = $urandom;
    core_lat = 6;
    start_cnt = 0;
    applyStimulus(8, 0, 0, 0);
    computeExpected();
    @(negedge clk);
    key_we = 1'b1; key_addr = 3'd0; key_data = 32'h0;
    @(negedge clk);
    key_we = 1'b0;
    collectOutput(1);
    blk_m++;
    checkOutput("lockout_blk_count", blk_count, 16'(blk_m));
    for (int w = 0; w < 8; w++) blk_in[w] = 32'h0;
    core_lat = 1;
    runBlock(0, 0, 0);

    // Timeout: the core never answers.
    core_hold = 1'b1;
    for (int w = 0; w < 8; w++) blk_in[w] = $urandom;
    applyStimulus(8, 1, 0, 0);
    ovalid_seen = 1'b0;
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    checkOutput("timeout_busy_cycles", cnt, TMO + 1);
    checkOutput("timeout_err_set", timeout_err, 1);
    checkOutput("timeout_back_to_load", in_ready, 1);
    checkOutput("timeout_no_ovalid", ovalid_seen, 0);
    checkOutput("timeout_blk_count", blk_count, 16'(blk_m));
    core_hold = 1'b0;
    for (int w = 0; w < 8; w++) blk_in[w] = $urandom;
    core_lat = 2;
    start_cnt = 0;
    applyStimulus(8, 0, 0, 1);
    computeExpected();
    collectOutput(0);
    blk_m++;
    checkOutput("post_timeout_blk_count", blk_count, 16'(blk_m));

    // Reset after five input words; partial block dropped, key cleared.
    for (int w = 0; w < 8; w++) blk_in[w] = $urandom;
    applyStimulus(5, 1, 0, 0);
    #2 rst = 1'b1;
    #1 checkResetValues("midload");
    for (int a = 0; a < 8; a++) key_m[a] = '0;
    blk_m = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int w = 0; w < 8; w++) blk_in[w] = $urandom;
    core_lat = 2;
    runBlock(1, 1, 1);

    // Reset while waiting on the core; its late result must be ignored.
    for (int w = 0; w < 8; w++) blk_in[w] = $urandom;
    core_lat = 5;
    applyStimulus(8, 0, 0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 checkResetValues("midwait");
    for (int a = 0; a < 8; a++) key_m[a] = '0;
    blk_m = 0;
    @(negedge clk);
    rst = 1'b0;
    ovalid_seen = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("late_result_no_ovalid", ovalid_seen, 0);
    checkOutput("late_result_blk_count", blk_count, 0);
    writeKeyAll(32'hffffffff);
    for (int w = 0; w < 8; w++) blk_in[w] = $urandom;
    core_lat = 0;
    runBlock(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
